eth_rx_da_filter: RTL and testbench

Destination-address filter and length guard on the 10G MAC receive AXI-Stream, in the Clk156M25 domain, directly upstream of the MAC-to-XFI receive FIFO bridge. Each frame's DA is inspected on its first beat. Frames addressed to the local MAC, broadcast, or (optionally) multicast are forwarded whole. All others are discarded whole. Over-length frames are cut at MAX_BEATS with a forced tlast, and the remainder is discarded. Per-class frame counters feed the port status registers.

---
 rtl/eth_rx_pkg.sv | 27 ++
 rtl/rx_axis_skid.sv | 64 ++++++
 rtl/eth_rx_da_filter.sv | 165 ++++++++++++++++
 tb/tb_eth_rx_da_filter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// ----------------------------------------------------------------------------
// eth_rx_pkg
// Shared definitions for the 10G MAC receive path: broadcast address,
// one-hot state bit positions and the DA filter state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package eth_rx_pkg;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // One-hot bit positions of the filter state register
    localparam int HEAD  = 0;
    localparam int PASS  = 1;
    localparam int DROP  = 2;
    localparam int DRAIN = 3;

    // Skid entry: {last, keep[7:0], data[63:0]}
    localparam int SKID_W = 73;

    typedef enum logic [3:0] {
        StHead  = 4'(1 << HEAD),
        StPass  = 4'(1 << PASS),
        StDrop  = 4'(1 << DROP),
        StDrain = 4'(1 << DRAIN)
    } rxFiltState_t;

endpackage

// File: rtl/rx_axis_skid.sv
// ----------------------------------------------------------------------------
// rx_axis_skid
// Two-entry AXI-Stream skid buffer with registered input ready. Output is
// driven straight from the storage registers, so a written beat appears on
// outValid one cycle after it is accepted and stays put while stalled.
// Ports:
//   Clk156M25, RstMac_n      clock, async active-low reset
//   inData/inValid/inReady   upstream side (inReady is a flop)
//   outData/outValid/outReady downstream side
// ----------------------------------------------------------------------------
module rx_axis_skid #(
    parameter int W = 73
) (
    input  logic         Clk156M25,
    input  logic         RstMac_n,
    input  logic [W-1:0] inData,
    input  logic         inValid,
    output logic         inReady,
    output logic [W-1:0] outData,
    output logic         outValid,
    input  logic         outReady
);

    logic [W-1:0] mem [2];
    logic         wrPtr;
    logic         rdPtr;
    logic [1:0]   count;
    logic [1:0]   countNext;
    logic         readyReg;
    logic         push;
    logic         pop;

    assign push      = inValid & readyReg;
    assign pop       = outValid & outReady;
    assign countNext = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge Clk156M25 or negedge RstMac_n) begin
        if (!RstMac_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            count    <= 2'd0;
            readyReg <= 1'b0;
        end else begin
            if (push) begin
                mem[wrPtr] <= inData;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count    <= countNext;
            // Ready looks at the occupancy after this edge, so it can drop
            // the same cycle the second entry fills.
            readyReg <= (countNext != 2'd2);
        end
    end

    assign inReady  = readyReg;
    assign outData  = mem[rdPtr];
    assign outValid = (count != 2'd0);

endmodule

// File: rtl/eth_rx_da_filter.sv
// ----------------------------------------------------------------------------
// eth_rx_da_filter
// Destination-address filter and length guard on the 10G MAC receive
// AXI-Stream. The DA is judged on the first beat; matching frames are
// forwarded, others discarded whole. Frames longer than MAX_BEATS are cut
// with a forced tlast and the tail is discarded.
// Build option: RX_DA_FILT_CNT_EN builds the pass/drop/trunc frame counters
// and CntClr; without it the counter outputs are constant zero.
// Ports:
//   Clk156M25, RstMac_n          clock, async active-low reset
//   FiltEn, LocalMac             quasi-static filter configuration
//   s_axis_*                     MAC receive stream in
//   m_axis_*                     filtered stream out (via 2-entry skid)
//   CntClr                       synchronous counter clear
//   PassPkg_Cnt/DropPkg_Cnt/TruncPkg_Cnt  frame counters
// ----------------------------------------------------------------------------
module eth_rx_da_filter
    import eth_rx_pkg::*;
#(
    parameter int MAX_BEATS    = 191,
    parameter int ACCEPT_MCAST = 1
) (
    input  logic        Clk156M25,
    input  logic        RstMac_n,
    input  logic        FiltEn,
    input  logic [47:0] LocalMac,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    input  logic        CntClr,
    output logic [31:0] PassPkg_Cnt,
    output logic [31:0] DropPkg_Cnt,
    output logic [31:0] TruncPkg_Cnt
);

    // state   | meaning
    // StHead  | waiting for the first beat; decision taken on it
    // StPass  | forwarding an accepted frame, counting beats
    // StDrop  | discarding the rest of a rejected frame
    // StDrain | discarding the tail of a truncated frame
    rxFiltState_t state, stateNext;

    logic [11:0] beatCnt, beatCntNext;
    logic [47:0] da;
    logic        daOk;
    logic        accBeat;
    logic        push;
    logic        pushLast;
    logic        incPass, incDrop, incTrunc;
    logic        skidReady;
    logic        discarding;

    localparam logic MCAST_EN = (ACCEPT_MCAST != 0);

    assign da = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                 s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};

    assign daOk = !FiltEn || (da == LocalMac) || (da == BCAST_MAC) ||
                  (MCAST_EN && s_axis_tdata[0]);

    assign discarding    = (state == StDrop) || (state == StDrain);
    assign s_axis_tready = discarding ? 1'b1 : skidReady;
    assign accBeat       = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge Clk156M25 or negedge RstMac_n) begin
        if (!RstMac_n) begin
            state   <= StHead;
            beatCnt <= 12'd0;
        end else begin
            state   <= stateNext;
            beatCnt <= beatCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        beatCntNext = beatCnt;
        push        = 1'b0;
        pushLast    = s_axis_tlast;
        incPass     = 1'b0;
        incDrop     = 1'b0;
        incTrunc    = 1'b0;
        unique case (state)
            StHead: begin
                beatCntNext = 12'd0;
                if (accBeat) begin
                    if (daOk) begin
                        push = 1'b1;
                        if (s_axis_tlast) begin
                            incPass = 1'b1;
                        end else begin
                            beatCntNext = 12'd1;
                            stateNext   = StPass;
                        end
                    end else begin
                        incDrop = 1'b1;
                        if (!s_axis_tlast) stateNext = StDrop;
                    end
                end
            end
            StPass: begin
                if (accBeat) begin
                    push        = 1'b1;
                    beatCntNext = beatCnt + 12'd1;
                    if (s_axis_tlast) begin
                        incPass   = 1'b1;
                        stateNext = StHead;
                    end else if (beatCnt == 12'(MAX_BEATS - 1)) begin
                        pushLast  = 1'b1;
                        incPass   = 1'b1;
                        incTrunc  = 1'b1;
                        stateNext = StDrain;
                    end
                end
            end
            StDrop, StDrain: begin
                if (accBeat && s_axis_tlast) stateNext = StHead;
            end
            default: stateNext = StHead;
        endcase
    end

    rx_axis_skid #(.W(SKID_W)) uSkid (
        .Clk156M25 (Clk156M25),
        .RstMac_n  (RstMac_n),
        .inData    ({pushLast, s_axis_tkeep, s_axis_tdata}),
        .inValid   (push),
        .inReady   (skidReady),
        .outData   ({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
        .outValid  (m_axis_tvalid),
        .outReady  (m_axis_tready)
    );

`ifdef RX_DA_FILT_CNT_EN
    always_ff @(posedge Clk156M25 or negedge RstMac_n) begin
        if (!RstMac_n) begin
            PassPkg_Cnt  <= 32'h0;
            DropPkg_Cnt  <= 32'h0;
            TruncPkg_Cnt <= 32'h0;
        end else if (CntClr) begin
            PassPkg_Cnt  <= 32'h0;
            DropPkg_Cnt  <= 32'h0;
            TruncPkg_Cnt <= 32'h0;
        end else begin
            if (incPass)  PassPkg_Cnt  <= PassPkg_Cnt + 32'h1;
            if (incDrop)  DropPkg_Cnt  <= DropPkg_Cnt + 32'h1;
            if (incTrunc) TruncPkg_Cnt <= TruncPkg_Cnt + 32'h1;
        end
    end
`else
    logic unusedCntSig;
    assign unusedCntSig  = ^{CntClr, incPass, incDrop, incTrunc};
    assign PassPkg_Cnt   = 32'h0;
    assign DropPkg_Cnt   = 32'h0;
    assign TruncPkg_Cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_eth_rx_da_filter.sv
// ----------------------------------------------------------------------------
// tb_eth_rx_da_filter
// Scoreboard bench for eth_rx_da_filter: a frame-level model pushes expected
// output beats when stimulus is driven; a monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_eth_rx_da_filter;

    localparam int MAX_B = 191;
    localparam int MCAST = 0;
    localparam logic [47:0] MY_MAC = 48'h00_0A_35_01_02_03;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    logic        Clk156M25 = 1'b0;
    logic        RstMac_n;
    logic        FiltEn;
    logic [47:0] LocalMac;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        CntClr;
    logic [31:0] PassPkg_Cnt;
    logic [31:0] DropPkg_Cnt;
    logic [31:0] TruncPkg_Cnt;

    int checks   = 0;
    int failures = 0;
    int mPass    = 0;
    int mDrop    = 0;
    int mTrunc   = 0;
    bit toggleEn = 1'b0;

    logic [72:0] sb [$];
    logic [72:0] prevBeat;
    bit          prevStall = 1'b0;

    always #5 Clk156M25 = ~Clk156M25;

    eth_rx_da_filter #(.MAX_BEATS(MAX_B), .ACCEPT_MCAST(MCAST)) dut (
        .Clk156M25     (Clk156M25),
        .RstMac_n      (RstMac_n),
        .FiltEn        (FiltEn),
        .LocalMac      (LocalMac),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .CntClr        (CntClr),
        .PassPkg_Cnt   (PassPkg_Cnt),
        .DropPkg_Cnt   (DropPkg_Cnt),
        .TruncPkg_Cnt  (TruncPkg_Cnt)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expCnt(input int v);
`ifdef RX_DA_FILT_CNT_EN
        return 32'(v);
`else
        return 32'h0;
`endif
    endfunction

    task automatic chkCounters(input string tag);
        chk({tag, "_pass"},  PassPkg_Cnt,  expCnt(mPass));
        chk({tag, "_drop"},  DropPkg_Cnt,  expCnt(mDrop));
        chk({tag, "_trunc"}, TruncPkg_Cnt, expCnt(mTrunc));
    endtask

    // Output monitor: compares transfers against the scoreboard and checks
    // that a stalled beat does not change.
    always @(negedge Clk156M25) begin
        if (!RstMac_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall)
                chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                            {1'b1, prevBeat});
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, sb.pop_front());
                end
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevBeat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    // Downstream ready: held high, or toggled every cycle when enabled
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge Clk156M25);
            #1;
            m_axis_tready = toggleEn ? ~m_axis_tready : 1'b1;
        end
    end

    // Drives one frame; abortAt>=0 asserts reset while that beat is presented.
    task automatic sendFrame(input logic [47:0] da, input int n, input int gap,
                             input int abortAt, input bit clr);
        bit acc;
        logic [63:0] d;
        logic [7:0]  k;
        bit lastO;
        int wd;
        acc = !FiltEn || da == LocalMac || da == BCAST || (MCAST != 0 && da[40]);
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) begin
                d[7:0]   = da[47:40];
                d[15:8]  = da[39:32];
                d[23:16] = da[31:24];
                d[31:24] = da[23:16];
                d[39:32] = da[15:8];
                d[47:40] = da[7:0];
            end
            k = (i == n - 1) ? 8'h3F : 8'hFF;
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = (i == n - 1);
            s_axis_tvalid = 1'b1;
            CntClr        = clr && (i == 0);
            if (i == abortAt) begin
                #2;
                RstMac_n = 1'b0;
                return;
            end
            if (i > 0 && (!acc || i >= MAX_B))
                chk("discard_rdy", s_axis_tready, 1);
            wd = 0;
            while (!s_axis_tready && wd < 1000) begin
                @(posedge Clk156M25);
                #1;
                wd++;
            end
            if (wd >= 1000) chk("rdy_timeout", 0, 1);
            lastO = (i == n - 1) || (i == MAX_B - 1);
            if (acc && i < MAX_B) sb.push_back({lastO, k, d});
            @(posedge Clk156M25);
            #1;
            s_axis_tvalid = 1'b0;
            CntClr        = 1'b0;
            repeat (gap < 0 ? $urandom_range(0, 2) : gap) begin
                @(posedge Clk156M25);
                #1;
            end
        end
        if (acc) mPass++;
        else     mDrop++;
        if (acc && n > MAX_B) mTrunc++;
        if (clr) begin
            mPass  = 0;
            mDrop  = 0;
            mTrunc = 0;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge Clk156M25);
            n++;
        end
        chk({tag, "_drain"}, sb.size(), 0);
        repeat (3) @(posedge Clk156M25);
        #1;
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_tready"}, s_axis_tready, 0);
        chk({tag, "_mout"}, {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
        chk({tag, "_cnts"}, {PassPkg_Cnt, DropPkg_Cnt, TruncPkg_Cnt}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RstMac_n      = 1'b0;
        FiltEn        = 1'b1;
        LocalMac      = MY_MAC;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        CntClr        = 1'b0;

        repeat (3) @(posedge Clk156M25);
        #1;
        chkResetOutputs("rst");
        RstMac_n = 1'b1;
        @(posedge Clk156M25);
        #1;
        chk("rst_rel_tready", s_axis_tready, 1);

        // Matching unicast, mismatching unicast, broadcast
        sendFrame(MY_MAC, 8, 0, -1, 0);
        waitIdle("ucast");
        chkCounters("ucast");
        sendFrame(48'h00_0A_35_01_02_04, 8, 0, -1, 0);
        waitIdle("miss");
        chkCounters("miss");
        sendFrame(BCAST, 8, 0, -1, 0);
        waitIdle("bcast");
        chkCounters("bcast");

        // Multicast dropped when filtering, forwarded with filtering off
        sendFrame(48'h01_00_5E_00_00_01, 6, 0, -1, 0);
        waitIdle("mcast_filt");
        chkCounters("mcast_filt");
        FiltEn = 1'b0;
        sendFrame(48'h01_00_5E_00_00_01, 6, 0, -1, 0);
        waitIdle("mcast_open");
        chkCounters("mcast_open");
        FiltEn = 1'b1;

        // Length guard around MAX_BEATS
        sendFrame(MY_MAC, 200, 0, -1, 0);
        waitIdle("trunc200");
        chkCounters("trunc200");
        sendFrame(MY_MAC, MAX_B, 0, -1, 0);
        waitIdle("exact191");
        chkCounters("exact191");
        sendFrame(MY_MAC, MAX_B + 1, -1, -1, 0);
        waitIdle("trunc192");
        chkCounters("trunc192");

        // Back-to-back frames against a toggling downstream ready
        toggleEn = 1'b1;
        for (int f = 0; f < 20; f++) sendFrame(MY_MAC, 1, 0, -1, 0);
        sendFrame(48'h00_0A_35_01_02_04, 3, 0, -1, 0);
        sendFrame(MY_MAC, 5, 0, -1, 0);
        sendFrame(BCAST, 1, 0, -1, 0);
        waitIdle("toggle");
        chkCounters("toggle");
        toggleEn = 1'b0;
        repeat (2) @(posedge Clk156M25);
        #1;

        // Reset asserted while beat 4 of a 10-beat frame is presented
        sendFrame(MY_MAC, 10, 0, 3, 0);
        #1;
        chkResetOutputs("midrst");
        sb.delete();
        s_axis_tvalid = 1'b0;
        mPass  = 0;
        mDrop  = 0;
        mTrunc = 0;
        repeat (2) @(posedge Clk156M25);
        #1;
        RstMac_n = 1'b1;
        @(posedge Clk156M25);
        #1;
        chk("midrst_rel_tready", s_axis_tready, 1);
        sendFrame(48'h00_0A_35_01_02_04, 4, 0, -1, 0);
        sendFrame(MY_MAC, 7, 0, -1, 0);
        waitIdle("postrst");
        chkCounters("postrst");

        // Counter clear coinciding with a pass event
        sendFrame(MY_MAC, 1, 0, -1, 1);
        waitIdle("clr");
        chkCounters("clr");
        sendFrame(MY_MAC, 2, 0, -1, 0);
        waitIdle("after_clr");
        chkCounters("after_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
